data_mem_access_unit: RTL and testbench

- Sits between the single-cycle datapath's load/store path and the word-only data memory.
- Converts core byte-addressed requests (lb/lbu/lh/lhu/lw/sb/sh/sw) into word-indexed memory transactions.
- Sub-word stores use a read-modify-write sequence; loads are extracted and sign- or zero-extended.
- Holds `busy` high while a transaction is in flight, so the core stalls.

---
 rtl/data_mem_access_unit.sv | 177 +++++++++++++++++
 tb/tb_data_mem_access_unit.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_access_unit.sv
// data_mem_access_unit
//   Bridges the core's byte-addressed load/store path to a word-only data
//   memory. Loads read one word and extract/extend the addressed lane.
//   Word stores write directly. Byte/half stores read the word, merge the
//   new lane and write the result back (read-modify-write).
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-low reset
//   req_valid       request strobe, only looked at while idle
//   req_we          1 = store, 0 = load
//   req_size        00 byte, 01 half, 10 word, 11 illegal
//   req_signed      loads: 1 sign-extend, 0 zero-extend
//   req_addr        byte address
//   req_wdata       store data (byte/half in the low bits)
//   busy            high while a transaction is in flight (core stalls)
//   rsp_valid       one-cycle completion pulse
//   rsp_rdata       load result (0 for stores and errors)
//   rsp_err         misaligned, out-of-range or illegal size
//   mem_A           word index to memory
//   mem_WD, mem_WE  memory write data / enable
//   mem_RD          combinational memory read data at mem_A
module data_mem_access_unit #(
    parameter int DEPTH = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        busy,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] mem_A,
    output logic [31:0] mem_WD,
    output logic        mem_WE,
    input  logic [31:0] mem_RD
);

    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    typedef enum logic [1:0] {IDLE, RD, WR} state_t;

    state_t      state, state_next;

    logic [29:0] idx_q;
    logic [1:0]  lane_q;
    logic [1:0]  size_q;
    logic        we_q;
    logic        sgn_q;
    logic [31:0] wdata_q;
    logic [31:0] merge_q;

    logic        accept;
    logic        req_err;

    // Lane extraction with sign/zero extension for loads.
    function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] lane,
                                            input logic [1:0] size, input logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{lane, 3'b000} +: 8];
        h = w[{lane[1], 4'b0000} +: 16];
        case (size)
            2'b00:   extract = {{24{sgn & b[7]}}, b};
            2'b01:   extract = {{16{sgn & h[15]}}, h};
            default: extract = w;
        endcase
    endfunction

    // Replace only the addressed lane(s); other lanes keep the memory value.
    function automatic logic [31:0] merge(input logic [31:0] w, input logic [31:0] wd,
                                          input logic [1:0] lane, input logic [1:0] size);
        logic [31:0] m;
        m = w;
        if (size == 2'b00)
            m[{lane, 3'b000} +: 8] = wd[7:0];
        else
            m[{lane[1], 4'b0000} +: 16] = wd[15:0];
        merge = m;
    endfunction

    assign accept = (state == IDLE) && req_valid;

    always_comb begin
        req_err = 1'b0;
        if (req_size == 2'b11)                         req_err = 1'b1;
        if (req_size == 2'b01 && req_addr[0])          req_err = 1'b1;
        if (req_size == 2'b10 && req_addr[1:0] != 2'b00) req_err = 1'b1;
        if ({2'b00, req_addr[31:2]} >= DEPTH_W)        req_err = 1'b1;
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // Next state. Word stores skip the read; sub-word stores read first.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept && !req_err)
                    state_next = (req_we && req_size == 2'b10) ? WR : RD;
            end
            RD:      state_next = we_q ? WR : IDLE;
            WR:      state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Memory-side outputs decode straight from state so they are quiet in IDLE
    // and immediately after reset.
    always_comb begin
        busy   = (state != IDLE);
        mem_WE = (state == WR);
        mem_A  = (state != IDLE) ? {2'b00, idx_q} : 32'd0;
        mem_WD = 32'd0;
        if (state == WR)
            mem_WD = (size_q == 2'b10) ? wdata_q : merge_q;
    end

    // Request latch, merge word and registered response.
    always_ff @(posedge clk) begin
        if (!rst) begin
            idx_q     <= '0;
            lane_q    <= '0;
            size_q    <= '0;
            we_q      <= 1'b0;
            sgn_q     <= 1'b0;
            wdata_q   <= '0;
            merge_q   <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        idx_q     <= req_addr[31:2];
                        lane_q    <= req_addr[1:0];
                        size_q    <= req_size;
                        we_q      <= req_we;
                        sgn_q     <= req_signed;
                        wdata_q   <= req_wdata;
                        rsp_rdata <= '0;
                        // Rejected requests answer next cycle without touching memory.
                        if (req_err) begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                        end
                    end
                end
                RD: begin
                    if (!we_q) begin
                        rsp_rdata <= extract(mem_RD, lane_q, size_q, sgn_q);
                        rsp_valid <= 1'b1;
                    end else begin
                        merge_q <= merge(mem_RD, wdata_q, lane_q, size_q);
                    end
                end
                WR: begin
                    rsp_rdata <= '0;
                    rsp_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_access_unit.sv
module tb_data_mem_access_unit;

    localparam int DEPTH = 100;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_we, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        busy, rsp_valid, rsp_err, mem_WE;
    logic [31:0] rsp_rdata, mem_A, mem_WD, mem_RD;

    logic [31:0] mem [DEPTH];
    logic        pl_en;
    logic [6:0]  pl_idx;
    logic [31:0] pl_data;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    data_mem_access_unit #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
        .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
        .busy(busy), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_A(mem_A), .mem_WD(mem_WD), .mem_WE(mem_WE), .mem_RD(mem_RD)
    );

    // Word memory model: combinational read, write at the end of a WE cycle.
    assign mem_RD = (mem_A < DEPTH) ? mem[mem_A[6:0]] : 32'd0;

    always @(posedge clk) begin
        if (mem_WE && mem_A < DEPTH) mem[mem_A[6:0]] <= mem_WD;
        if (pl_en) mem[pl_idx] <= pl_data;
    end

    task automatic preload(input logic [6:0] i, input logic [31:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_idx = i; pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // Issues one request and observes it until rsp_valid (cycle 0 = accept edge).
    task automatic run_req(input logic we, input logic [1:0] sz, input logic sg,
                           input logic [31:0] a, input logic [31:0] wdin,
                           output int lat, output logic [31:0] rdata, output logic err,
                           output int we_cnt, output logic [31:0] wa, output logic [31:0] wd);
        lat = -1; rdata = 32'hxxxxxxxx; err = 1'bx; we_cnt = 0; wa = 0; wd = 0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = wdin;
        @(negedge clk);
        req_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (mem_WE) begin we_cnt++; wa = mem_A; wd = mem_WD; end
            if (rsp_valid) begin lat = c; rdata = rsp_rdata; err = rsp_err; break; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        logic bad;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, rsp_valid, rsp_err, mem_WE, rsp_rdata, mem_A, mem_WD} !== 100'd0) begin
            errors++; $display("FAIL reset_outputs: got busy=%b v=%b e=%b we=%b rd=%h a=%h wd=%h required all 0",
                               busy, rsp_valid, rsp_err, mem_WE, rsp_rdata, mem_A, mem_WD);
        end
        rst = 1'b1;
        preload(7'd5, 32'h11111111);
        // sb to word 5, then reset while in RD
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 32'h15; req_wdata = 32'hAA;
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL reset_pre_busy: got %b required 1", busy); end
        rst = 1'b0;
        bad = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (mem_WE !== 1'b0 || rsp_valid !== 1'b0) bad = 1'b1;
        end
        checks++;
        if ({busy, rsp_valid, rsp_err, mem_WE, rsp_rdata, mem_A, mem_WD} !== 100'd0) begin
            errors++; $display("FAIL reset_mid_outputs: got busy=%b v=%b we=%b a=%h wd=%h required all 0",
                               busy, rsp_valid, mem_WE, mem_A, mem_WD);
        end
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (mem_WE !== 1'b0 || rsp_valid !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0) begin errors++; $display("FAIL reset_abandon: saw mem_WE or rsp_valid after reset, required none"); end
        checks++;
        if (mem[5] !== 32'h11111111) begin errors++; $display("FAIL reset_mem: got %h required 11111111", mem[5]); end
    endtask

    task automatic test_word;
        int lat, wc; logic [31:0] rd, wa, wd; logic e;
        run_req(1'b1, 2'b10, 1'b0, 32'h8, 32'hDEADBEEF, lat, rd, e, wc, wa, wd);
        checks++; if (lat !== 2) begin errors++; $display("FAIL sw_latency: got %0d required 2", lat); end
        checks++; if (wc !== 1) begin errors++; $display("FAIL sw_we_cycles: got %0d required 1", wc); end
        checks++; if (wa !== 32'd2) begin errors++; $display("FAIL sw_addr: got %h required 2", wa); end
        checks++; if (wd !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_wdata: got %h required deadbeef", wd); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL sw_err: got %b required 0", e); end
        run_req(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, lat, rd, e, wc, wa, wd);
        checks++; if (lat !== 2) begin errors++; $display("FAIL lw_latency: got %0d required 2", lat); end
        checks++; if (rd !== 32'hDEADBEEF || e !== 1'b0) begin errors++; $display("FAIL lw_data: got %h err=%b required deadbeef err=0", rd, e); end
        checks++; if (wc !== 0) begin errors++; $display("FAIL lw_no_write: got %0d required 0", wc); end
    endtask

    task automatic test_rmw;
        int lat, wc; logic [31:0] rd, wa, wd; logic e;
        preload(7'd2, 32'h11223344);
        run_req(1'b1, 2'b00, 1'b0, 32'h9, 32'h000000AB, lat, rd, e, wc, wa, wd);
        checks++; if (lat !== 3) begin errors++; $display("FAIL sb_latency: got %0d required 3", lat); end
        checks++; if (wd !== 32'h1122AB44 || wc !== 1) begin errors++; $display("FAIL sb_merge: got %h (we %0d) required 1122ab44 (we 1)", wd, wc); end
        checks++; if (rd !== 32'd0 || e !== 1'b0) begin errors++; $display("FAIL sb_rsp: got rd=%h err=%b required 0/0", rd, e); end
        run_req(1'b1, 2'b01, 1'b0, 32'hA, 32'h0000CDEF, lat, rd, e, wc, wa, wd);
        checks++; if (lat !== 3) begin errors++; $display("FAIL sh_latency: got %0d required 3", lat); end
        checks++; if (wd !== 32'hCDEFAB44) begin errors++; $display("FAIL sh_merge: got %h required cdefab44", wd); end
        @(negedge clk);
        checks++; if (mem[2] !== 32'hCDEFAB44) begin errors++; $display("FAIL rmw_mem: got %h required cdefab44", mem[2]); end
    endtask

    task automatic test_load_ext;
        int lat, wc; logic [31:0] rd, wa, wd; logic e;
        logic [1:0]  sz [7]  = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b10};
        logic        sg [7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [31:0] ad [7]  = '{32'h9, 32'hA, 32'hA, 32'hA, 32'hA, 32'hB, 32'h18C};
        logic [31:0] ex [7]  = '{32'h0000007F, 32'hFFFFFFFF, 32'h000000FF, 32'hFFFF80FF,
                                 32'h000080FF, 32'hFFFFFF80, 32'h0BADF00D};
        preload(7'd2, 32'h80FF7F01);
        preload(7'd99, 32'h0BADF00D);
        for (int i = 0; i < 7; i++) begin
            run_req(1'b0, sz[i], sg[i], ad[i], 32'h0, lat, rd, e, wc, wa, wd);
            checks++;
            if (rd !== ex[i] || e !== 1'b0 || lat !== 2) begin
                errors++; $display("FAIL load_ext[%0d]: got %h err=%b lat=%0d required %h err=0 lat=2",
                                   i, rd, e, lat, ex[i]);
            end
        end
    endtask

    task automatic test_errors;
        int lat, wc; logic [31:0] rd, wa, wd; logic e;
        logic        we [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [1:0]  sz [4] = '{2'b01, 2'b10, 2'b10, 2'b11};
        logic [31:0] ad [4] = '{32'h3, 32'h6, 32'h190, 32'h0};
        for (int i = 0; i < 4; i++) begin
            run_req(we[i], sz[i], 1'b1, ad[i], 32'hFFFFFFFF, lat, rd, e, wc, wa, wd);
            checks++;
            if (lat !== 1 || e !== 1'b1 || rd !== 32'd0 || wc !== 0) begin
                errors++; $display("FAIL error[%0d]: got lat=%0d err=%b rd=%h we=%0d required 1/1/0/0",
                                   i, lat, e, rd, wc);
            end
        end
    endtask

    task automatic test_back_to_back;
        int lat, wc, nrsp; logic [31:0] rd, wa, wd; logic e;
        logic [31:0] rd2;
        preload(7'd3, 32'hCAFEF00D);
        run_req(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, lat, rd, e, wc, wa, wd);
        checks++; if (lat !== 2) begin errors++; $display("FAIL b2b_first: got lat=%0d required 2", lat); end
        // Same cycle as rsp_valid: new lw word 3
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_signed = 1'b0; req_addr = 32'hC;
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %b required 1", busy); end
        // Request held while busy must be ignored (would be an error if taken)
        req_size = 2'b11; req_addr = 32'h1;
        nrsp = 0; rd2 = 32'd0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            req_valid = (c == 0) ? 1'b0 : req_valid;
            if (rsp_valid) begin nrsp++; rd2 = rsp_rdata; end
        end
        checks++; if (nrsp !== 1) begin errors++; $display("FAIL b2b_rsp_count: got %0d required 1", nrsp); end
        checks++; if (rd2 !== 32'hCAFEF00D) begin errors++; $display("FAIL b2b_data: got %h required cafef00d", rd2); end
    endtask

    initial begin
        rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 32'd0; req_wdata = 32'd0; pl_en = 1'b0; pl_idx = 7'd0; pl_data = 32'd0;
        test_reset();
        test_word();
        test_rmw();
        test_load_ext();
        test_errors();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
